mux_buf_4to1: RTL and testbench

- Four-input, one-output multiplexer whose selection is built from one enable-buffer per data input.
- Exactly one buffer is enabled for any select code.
- The selected value is available combinationally and as a registered output.
- Used as a generic leaf select element in combinational and datapath blocks; WIDTH scales it from a single bit to a bus.

---
 rtl/mux_buf_4to1.sv | 43 ++++
 tb/tb_mux_buf_4to1.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/mux_buf_4to1.sv
// mux_buf_4to1: 4:1 mux built from one-hot enabled buffers, with an optional
// enable-gated output register.
module mux_buf_4to1 #(
    parameter int WIDTH   = 1,
    parameter bit REG_OUT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
    input  logic             a,
    input  logic             b,
    input  logic             en,
    output logic [WIDTH-1:0] y_comb,
    output logic [WIDTH-1:0] y
);
    logic [3:0] buf_en;

    // An unknown select propagates X through the shift, so y_comb goes X.
    assign buf_en = 4'b0001 << {a, b};

    assign y_comb = ({WIDTH{buf_en[0]}} & d0)
                  | ({WIDTH{buf_en[1]}} & d1)
                  | ({WIDTH{buf_en[2]}} & d2)
                  | ({WIDTH{buf_en[3]}} & d3);

    generate
        if (REG_OUT) begin : g_reg
            logic [WIDTH-1:0] y_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    y_q <= '0;
                else if (en)
                    y_q <= y_comb;
            end
            assign y = y_q;
        end else begin : g_comb
            assign y = y_comb;
        end
    endgenerate
endmodule

// File: tb/tb_mux_buf_4to1.sv
// tb_mux_buf_4to1: directed and randomized checks of the registered 1-bit mux
// and a combinational 8-bit variant against a select-indexed reference model.
module tb_mux_buf_4to1;
    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       en = 1'b0;
    logic       a = 1'b0;
    logic       b = 1'b0;
    logic [0:0] d0 = '0, d1 = '0, d2 = '0, d3 = '0;
    logic [0:0] y_comb, y;
    logic [7:0] w0 = '0, w1 = '0, w2 = '0, w3 = '0;
    logic [7:0] wy_comb, wy;
    logic [0:0] exp_y;
    int n_chk = 0;
    int n_fail = 0;

    mux_buf_4to1 #(.WIDTH(1), .REG_OUT(1)) dut (
        .clk(clk), .rst_n(rst_n), .d0(d0), .d1(d1), .d2(d2), .d3(d3),
        .a(a), .b(b), .en(en), .y_comb(y_comb), .y(y)
    );

    mux_buf_4to1 #(.WIDTH(8), .REG_OUT(0)) dut_w (
        .clk(clk), .rst_n(rst_n), .d0(w0), .d1(w1), .d2(w2), .d3(w3),
        .a(a), .b(b), .en(en), .y_comb(wy_comb), .y(wy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [0:0] sel_bit();
        logic [0:0] v[4];
        v = '{d0, d1, d2, d3};
        return v[2*a + b];
    endfunction

    function automatic logic [7:0] sel_wide();
        logic [7:0] v[4];
        v = '{w0, w1, w2, w3};
        return v[2*a + b];
    endfunction

    task automatic drive(input logic [3:0] d, input logic sa, input logic sb);
        {d3, d2, d1, d0} = d;
        a = sa;
        b = sb;
    endtask

    // Register model: what y will hold after the coming rising edge.
    task automatic tick();
        if (rst_n && en)
            exp_y = sel_bit();
        @(posedge clk);
        #1;
    endtask

    initial begin
        exp_y = '0;
        drive(4'($urandom), 1'b1, 1'b0);
        #1 rst_n = 1'b0;
        #2;
        check("async_reset_y", 8'(y), 8'h00);
        check("reset_y_comb", 8'(y_comb), 8'(sel_bit()));
        en = 1'b1;
        @(posedge clk);
        #1;
        check("reset_hold_y", 8'(y), 8'h00);

        rst_n = 1'b1;
        drive(4'b0100, 1'b0, 1'b1);
        #1;
        check("d1_y_comb", 8'(y_comb), 8'h00);
        tick();
        check("d1_y", 8'(y), 8'h00);

        drive(4'b1101, 1'b1, 1'b0);
        #1;
        check("d2_y_comb", 8'(y_comb), 8'h01);
        tick();
        check("d2_y", 8'(y), 8'h01);

        drive(4'b0101, 1'b1, 1'b1);
        #1;
        check("d3a_y_comb", 8'(y_comb), 8'h00);
        drive(4'b0001, 1'b1, 1'b1);
        #1;
        check("d3b_y_comb", 8'(y_comb), 8'h00);
        tick();
        check("d3b_y", 8'(y), 8'h00);

        for (int i = 0; i < 64; i++) begin
            logic [5:0] v;
            v = 6'(i);
            drive(v[3:0], v[5], v[4]);
            w0 = 8'($urandom); w1 = 8'($urandom); w2 = 8'($urandom); w3 = 8'($urandom);
            #1;
            check("sweep_y_comb", 8'(y_comb), 8'(v[3:0] >> {v[5], v[4]}) & 8'h01);
            check("sweep_known", 8'($isunknown(y_comb)), 8'h00);
            check("sweep_wide", wy_comb, sel_wide());
        end
        tick();

        drive(4'b1000, 1'b1, 1'b1);
        tick();
        check("hold_pre_y", 8'(y), 8'h01);
        en = 1'b0;
        drive(4'b0111, 1'b1, 1'b1);
        #1;
        check("hold_y_comb", 8'(y_comb), 8'h00);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("hold_y", 8'(y), 8'h01);
        end
        #2 rst_n = 1'b0;
        #1;
        exp_y = '0;
        check("mid_reset_y", 8'(y), 8'h00);
        check("mid_reset_y_comb", 8'(y_comb), 8'h00);
        #1 rst_n = 1'b1;

        for (int i = 0; i < 300; i++) begin
            drive(4'($urandom), 1'($urandom), 1'($urandom));
            en = 1'($urandom);
            w0 = 8'($urandom); w1 = 8'($urandom); w2 = 8'($urandom); w3 = 8'($urandom);
            #1;
            check("rand_y_comb", 8'(y_comb), 8'(sel_bit()));
            check("rand_wide_comb", wy_comb, sel_wide());
            check("rand_wide_y", wy, sel_wide());
            if ($urandom_range(0, 15) == 0) begin
                rst_n = 1'b0;
                exp_y = '0;
                #1;
                check("rand_reset_y", 8'(y), 8'h00);
                check("rand_reset_wide_y", wy, sel_wide());
                rst_n = 1'b1;
            end
            tick();
            check("rand_y", 8'(y), 8'(exp_y));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
